// File: rtl/huffman_param_enc_pkg.sv
// Shared types for the Huffman encoder: FSM states, merge-tree node record and node ordering.
// Node fields are sized for the largest supported configuration; unused upper bits stay zero.
package huffman_pkg;

  localparam int unsigned MAX_NSYM = 16;
  localparam int unsigned MAX_CW   = 32;
  localparam int unsigned NODE_CW  = MAX_CW + $clog2(MAX_NSYM);
  localparam int unsigned IDX_W    = $clog2(MAX_NSYM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC,
    S_CNT_OUT,
    S_INIT,
    S_SCAN,
    S_MERGE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [NODE_CW-1:0]  cnt;
    logic [MAX_NSYM-1:0] members;
    logic [IDX_W-1:0]    min_idx;
    logic                active;
  } node_t;

  // Lower count wins; on equal counts the node with the larger min index is the smaller one.
  function automatic logic node_smaller(input node_t a, input node_t b);
    return (a.cnt < b.cnt) || ((a.cnt == b.cnt) && (a.min_idx > b.min_idx));
  endfunction

endpackage

// File: rtl/huffman_param_enc_if.sv
// Sample stream in, histogram and Huffman code tables out.
interface huffman_param_enc_if #(
  parameter int unsigned NSYM = 6,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned LW   = 8
);
  logic               gray_valid;
  logic [DW-1:0]      gray_data;
  logic               CNT_valid;
  logic [NSYM*CW-1:0] CNT;
  logic               code_valid;
  logic [NSYM*LW-1:0] HC;
  logic [NSYM*LW-1:0] M;

  modport master (
    output gray_valid, gray_data,
    input  CNT_valid, CNT, code_valid, HC, M
  );

  modport slave (
    input  gray_valid, gray_data,
    output CNT_valid, CNT, code_valid, HC, M
  );
endinterface

// File: rtl/huffman_param_enc_hist.sv
// Histogram bank: one counter per symbol 1..NSYM; clear+inc restarts the histogram with the current sample.
// HUFF_CNT_SAT_EN defined: counters saturate at all-ones; otherwise they wrap.
module huffman_hist #(
  parameter int unsigned NSYM = 6,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [DW-1:0]      data_i,
  output logic [NSYM*CW-1:0] cnt_o
);

  for (genvar i = 0; i < NSYM; i++) begin : g_bin
    logic          hit;
    logic [CW-1:0] cnt_q;

    assign hit = inc_i && (data_i == DW'(i + 1));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (clr_i) begin
        cnt_q <= hit ? CW'(1) : '0;
      end else if (hit) begin
`ifdef HUFF_CNT_SAT_EN
        if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + CW'(1);
`else
        cnt_q <= cnt_q + CW'(1);
`endif
      end
    end

    assign cnt_o[i*CW +: CW] = cnt_q;
  end

endmodule

// File: rtl/huffman_param_enc.sv
// Histogram + iterative Huffman code generator: counts symbols, then merges the two smallest nodes
// NSYM-1 times, growing right-aligned codes HC and masks M. Optional HUFF_CNT_SAT_EN saturates counts.
module huffman_param_enc
  import huffman_pkg::*;
#(
  parameter int unsigned NSYM = 6,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned LW   = 8
) (
  input logic                clk,
  input logic                reset,
  huffman_param_enc_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NSYM);
  localparam int unsigned LENW = $clog2(LW + 1);
  localparam int unsigned MRGW = $clog2(NSYM);

  state_e             state_q, state_d;
  logic               hist_clr, hist_inc;
  logic [NSYM*CW-1:0] cnt_w;

  node_t              nodes_q [NSYM];
  logic [LENW-1:0]    len_q   [NSYM];
  logic [LW-1:0]      hc_q    [NSYM];
  logic [LW-1:0]      m_q     [NSYM];
  logic [IDXW-1:0]    scan_idx_q, a_idx_q, b_idx_q;
  logic               a_vld_q, b_vld_q;
  logic [MRGW-1:0]    merge_cnt_q;
  logic               cnt_valid_q, code_valid_q;

  node_t              cand, node_a, node_b, merged;
  logic               take_a, take_b;

  huffman_hist #(
    .NSYM (NSYM),
    .DW   (DW),
    .CW   (CW)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (hist_clr),
    .inc_i  (hist_inc),
    .data_i (bus.gray_data),
    .cnt_o  (cnt_w)
  );

  // Running two-smallest search over the slot being scanned, and the merged node for MERGE.
  always_comb begin
    cand   = nodes_q[scan_idx_q];
    node_a = nodes_q[a_idx_q];
    node_b = nodes_q[b_idx_q];
    take_a = cand.active && (!a_vld_q || node_smaller(cand, node_a));
    take_b = cand.active && !take_a && (!b_vld_q || node_smaller(cand, node_b));
    merged = '{cnt:     node_a.cnt + node_b.cnt,
               members: node_a.members | node_b.members,
               min_idx: (node_a.min_idx < node_b.min_idx) ? node_a.min_idx : node_b.min_idx,
               active:  1'b1};
  end

  always_comb begin
    state_d  = state_q;
    hist_clr = 1'b0;
    hist_inc = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.gray_valid) begin
          hist_clr = 1'b1;
          hist_inc = 1'b1;
          state_d  = S_REC;
        end
      end
      S_REC: begin
        if (bus.gray_valid) hist_inc = 1'b1;
        else                state_d  = S_CNT_OUT;
      end
      S_CNT_OUT: state_d = S_INIT;
      S_INIT:    state_d = S_SCAN;
      S_SCAN:    if (scan_idx_q == IDXW'(NSYM - 1)) state_d = S_MERGE;
      S_MERGE:   state_d = (merge_cnt_q == MRGW'(NSYM - 2)) ? S_DONE : S_SCAN;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSYM; i++) begin
        nodes_q[i] <= '0;
        len_q[i]   <= '0;
        hc_q[i]    <= '0;
        m_q[i]     <= '0;
      end
      scan_idx_q   <= '0;
      a_idx_q      <= '0;
      b_idx_q      <= '0;
      a_vld_q      <= 1'b0;
      b_vld_q      <= 1'b0;
      merge_cnt_q  <= '0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      cnt_valid_q  <= (state_d == S_CNT_OUT);
      code_valid_q <= (state_d == S_DONE);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.gray_valid) begin
            for (int i = 0; i < NSYM; i++) begin
              hc_q[i] <= '0;
              m_q[i]  <= '0;
            end
          end
        end
        S_INIT: begin
          for (int i = 0; i < NSYM; i++) begin
            nodes_q[i] <= '{cnt:     NODE_CW'(cnt_w[i*CW +: CW]),
                            members: MAX_NSYM'(1) << i,
                            min_idx: IDX_W'(i),
                            active:  1'b1};
            len_q[i]   <= '0;
          end
          scan_idx_q  <= '0;
          a_vld_q     <= 1'b0;
          b_vld_q     <= 1'b0;
          merge_cnt_q <= '0;
        end
        S_SCAN: begin
          scan_idx_q <= (scan_idx_q == IDXW'(NSYM - 1)) ? '0 : scan_idx_q + IDXW'(1);
          if (take_a) begin
            a_idx_q <= scan_idx_q;
            a_vld_q <= 1'b1;
            b_idx_q <= a_idx_q;
            b_vld_q <= a_vld_q;
          end else if (take_b) begin
            b_idx_q <= scan_idx_q;
            b_vld_q <= 1'b1;
          end
        end
        S_MERGE: begin
          // Members of the smaller node get a 1 at their current depth, the other node's a 0.
          for (int s = 0; s < NSYM; s++) begin
            if (node_a.members[s]) hc_q[s] <= hc_q[s] | (LW'(1) << len_q[s]);
            if (node_a.members[s] || node_b.members[s]) begin
              m_q[s]   <= (m_q[s] << 1) | LW'(1);
              len_q[s] <= len_q[s] + LENW'(1);
            end
          end
          nodes_q[b_idx_q]        <= merged;
          nodes_q[a_idx_q].active <= 1'b0;
          merge_cnt_q             <= merge_cnt_q + MRGW'(1);
          a_vld_q                 <= 1'b0;
          b_vld_q                 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.CNT_valid  = cnt_valid_q;
  assign bus.CNT        = cnt_w;
  assign bus.code_valid = code_valid_q;

  for (genvar i = 0; i < NSYM; i++) begin : g_out
    assign bus.HC[i*LW +: LW] = hc_q[i];
    assign bus.M[i*LW +: LW]  = m_q[i];
  end

endmodule
